// File: rtl/rv_wb_pkg.sv
// Shared types and constants for the register-file writeback path:
// load funct3 encodings, the load-return queue entry and default sizes.
package rv_wb_pkg;

   localparam int WB_XLEN      = 32;
   localparam int LQ_DEPTH_DEF = 4;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;

   typedef struct packed {
      logic [4:0]         rd;
      logic [2:0]         funct3;
      logic [1:0]         addr_lo;
      logic [WB_XLEN-1:0] rdata;
   } lq_entry_t;

endpackage

// File: rtl/rv_load_extend.sv
// Combinational load data alignment and sign/zero extension.
// Picks the byte/half addressed by addr_lo out of an aligned word and
// extends it according to funct3; unknown funct3 codes pass the word through.
module rv_load_extend
   import rv_wb_pkg::*;
#(
   parameter int XLEN = WB_XLEN
) (
   input  logic [2:0]      funct3,
   input  logic [1:0]      addr_lo,
   input  logic [XLEN-1:0] rdata,
   output logic [XLEN-1:0] ext_data
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Select the addressed byte/half, then extend it per load type.
   always_comb begin
      byte_s   = 8'h00;
      half_s   = 16'h0000;
      ext_data = rdata;
      case (addr_lo)
         2'd0:    byte_s = rdata[7:0];
         2'd1:    byte_s = rdata[15:8];
         2'd2:    byte_s = rdata[23:16];
         2'd3:    byte_s = rdata[31:24];
         default: byte_s = 8'h00;
      endcase
      if (addr_lo[1]) begin
         half_s = rdata[31:16];
      end else begin
         half_s = rdata[15:0];
      end
      case (funct3)
         F3_LB:   ext_data = {{(XLEN-8){byte_s[7]}}, byte_s};
         F3_LBU:  ext_data = {{(XLEN-8){1'b0}}, byte_s};
         F3_LH:   ext_data = {{(XLEN-16){half_s[15]}}, half_s};
         F3_LHU:  ext_data = {{(XLEN-16){1'b0}}, half_s};
         F3_LW:   ext_data = rdata;
         default: ext_data = rdata;
      endcase
   end

endmodule

// File: rtl/rf_writeback_unit.sv
// Register-file write master: merges single-cycle ALU results with queued
// LSU load returns into one registered write port, ALU first. Also tracks a
// busy scoreboard of registers with loads outstanding.
// Optional build macro RF_WB_TRACE_EN adds a simulation-only write trace.
module rf_writeback_unit
   import rv_wb_pkg::*;
#(
   parameter int XLEN     = WB_XLEN,
   parameter int LQ_DEPTH = LQ_DEPTH_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      alu_valid,
   input  logic [4:0]                alu_rd,
   input  logic [XLEN-1:0]           alu_result,
   input  logic                      ld_issue,
   input  logic [4:0]                ld_issue_rd,
   input  logic                      lsu_valid,
   output logic                      lsu_ready,
   input  logic [4:0]                lsu_rd,
   input  logic [2:0]                lsu_funct3,
   input  logic [1:0]                lsu_addr_lo,
   input  logic [XLEN-1:0]           lsu_rdata,
   output logic                      rf_we,
   output logic [4:0]                rf_rd,
   output logic [XLEN-1:0]           rf_wdata,
   output logic [31:0]               busy_mask,
   output logic [$clog2(LQ_DEPTH):0] lq_count
);

   localparam int PW = $clog2(LQ_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] LQ_FULL = CW'(LQ_DEPTH);

   lq_entry_t         lq_mem_q [LQ_DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     lq_count_q, lq_count_d;
   logic              rf_we_q, rf_we_d;
   logic [4:0]        rf_rd_q, rf_rd_d;
   logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
   logic [31:0]       busy_q, busy_d;

   logic              push_s;
   logic              pop_s;
   lq_entry_t         head_s;
   lq_entry_t         push_entry_s;
   logic [XLEN-1:0]   head_ext_s;

   assign lsu_ready    = (lq_count_q != LQ_FULL);
   assign push_s       = lsu_valid && lsu_ready;
   // ALU has absolute priority; the queue drains only on ALU-idle cycles.
   assign pop_s        = !alu_valid && (lq_count_q != CW'(0));
   assign head_s       = lq_mem_q[rd_ptr_q];
   assign push_entry_s = '{rd: lsu_rd, funct3: lsu_funct3, addr_lo: lsu_addr_lo,
                           rdata: WB_XLEN'(lsu_rdata)};

   rv_load_extend #(.XLEN(XLEN)) u_load_extend (
      .funct3   (head_s.funct3),
      .addr_lo  (head_s.addr_lo),
      .rdata    (XLEN'(head_s.rdata)),
      .ext_data (head_ext_s)
   );

   // Next-state for queue pointers/count, write port and busy scoreboard.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      lq_count_d = lq_count_q;
      rf_we_d    = 1'b0;
      rf_rd_d    = rf_rd_q;
      rf_wdata_d = rf_wdata_q;
      busy_d     = busy_q;

      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   lq_count_d = lq_count_q + CW'(1);
         2'b01:   lq_count_d = lq_count_q - CW'(1);
         default: lq_count_d = lq_count_q;
      endcase

      // rd/wdata only move on a real write so they hold while rf_we is low;
      // an x0 destination still consumes its slot but never writes.
      if (alu_valid) begin
         if (alu_rd != 5'd0) begin
            rf_we_d    = 1'b1;
            rf_rd_d    = alu_rd;
            rf_wdata_d = alu_result;
         end else begin
            rf_we_d    = 1'b0;
         end
      end else if (pop_s) begin
         if (head_s.rd != 5'd0) begin
            rf_we_d    = 1'b1;
            rf_rd_d    = head_s.rd;
            rf_wdata_d = head_ext_s;
         end else begin
            rf_we_d    = 1'b0;
         end
      end else begin
         rf_we_d = 1'b0;
      end

      // Clear first so a same-cycle issue to the same register wins.
      if (pop_s) begin
         busy_d[head_s.rd] = 1'b0;
      end else begin
         busy_d = busy_d;
      end
      if (ld_issue && (ld_issue_rd != 5'd0)) begin
         busy_d[ld_issue_rd] = 1'b1;
      end else begin
         busy_d = busy_d;
      end
      busy_d[0] = 1'b0;
   end

   // State and output registers; reset drops any queued returns.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         lq_count_q <= '0;
         rf_we_q    <= 1'b0;
         rf_rd_q    <= 5'd0;
         rf_wdata_q <= '0;
         busy_q     <= 32'h0000_0000;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         lq_count_q <= lq_count_d;
         rf_we_q    <= rf_we_d;
         rf_rd_q    <= rf_rd_d;
         rf_wdata_q <= rf_wdata_d;
         busy_q     <= busy_d;
      end
   end

   // Queue storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         lq_mem_q[wr_ptr_q] <= push_entry_s;
      end
   end

   assign rf_we     = rf_we_q;
   assign rf_rd     = rf_rd_q;
   assign rf_wdata  = rf_wdata_q;
   assign busy_mask = busy_q;
   assign lq_count  = lq_count_q;

`ifdef RF_WB_TRACE_EN
   // Simulation trace of every committed register write.
   always_ff @(posedge clk) begin
      if (rst_n && rf_we_d) begin
         $display("%0t rf_wb: x%0d <= 0x%h (%s)", $time, rf_rd_d, rf_wdata_d,
                  alu_valid ? "ALU" : "LOAD");
      end
   end
`endif

endmodule

// File: tb/tb_rf_writeback_unit.sv
// Directed-vector bench for rf_writeback_unit with hand-computed expectations.
module tb_rf_writeback_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        alu_valid, ld_issue, lsu_valid;
   logic [4:0]  alu_rd, ld_issue_rd, lsu_rd;
   logic [31:0] alu_result, lsu_rdata;
   logic [2:0]  lsu_funct3;
   logic [1:0]  lsu_addr_lo;
   logic        lsu_ready, rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wdata, busy_mask;
   logic [2:0]  lq_count;

   int n_vec = 0;
   int n_err = 0;

   rf_writeback_unit dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result),
      .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd),
      .lsu_funct3(lsu_funct3), .lsu_addr_lo(lsu_addr_lo), .lsu_rdata(lsu_rdata),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
      .busy_mask(busy_mask), .lq_count(lq_count)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
      end
   endtask

   task automatic lsu_drive(input logic [4:0] rd, input logic [2:0] f3,
                            input logic [1:0] a, input logic [31:0] d);
      lsu_valid = 1'b1; lsu_rd = rd; lsu_funct3 = f3; lsu_addr_lo = a; lsu_rdata = d;
   endtask

   // Push one return, then pop it with no ALU traffic and check the write.
   task automatic load_ext_vec(input string tag, input logic [2:0] f3,
                               input logic [1:0] a, input logic [31:0] exp);
      lsu_drive(5'd7, f3, a, 32'h80FF7F01);
      @(negedge clk);
      lsu_valid = 1'b0;
      @(negedge clk);
      chk_eq({tag, "_we"}, {31'd0, rf_we}, 32'd1);
      chk_eq({tag, "_data"}, rf_wdata, exp);
   endtask

   initial begin
      alu_valid = 1'b0; alu_rd = 5'd0; alu_result = 32'd0;
      ld_issue = 1'b0; ld_issue_rd = 5'd0;
      lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_funct3 = 3'd0; lsu_addr_lo = 2'd0; lsu_rdata = 32'd0;
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk_eq("rst_we", {31'd0, rf_we}, 32'd0);
      chk_eq("rst_rd", {27'd0, rf_rd}, 32'd0);
      chk_eq("rst_wdata", rf_wdata, 32'd0);
      chk_eq("rst_busy", busy_mask, 32'd0);
      chk_eq("rst_count", {29'd0, lq_count}, 32'd0);
      chk_eq("rst_ready", {31'd0, lsu_ready}, 32'd1);
      rst_n = 1'b1;
      @(negedge clk);

      // ALU path
      alu_valid = 1'b1; alu_rd = 5'd5; alu_result = 32'hDEADBEEF;
      @(negedge clk);
      chk_eq("alu_we", {31'd0, rf_we}, 32'd1);
      chk_eq("alu_rd", {27'd0, rf_rd}, 32'd5);
      chk_eq("alu_data", rf_wdata, 32'hDEADBEEF);
      alu_rd = 5'd0; alu_result = 32'h12345678;
      @(negedge clk);
      chk_eq("alu_x0_we", {31'd0, rf_we}, 32'd0);
      chk_eq("alu_x0_rd_hold", {27'd0, rf_rd}, 32'd5);
      chk_eq("alu_x0_data_hold", rf_wdata, 32'hDEADBEEF);
      alu_valid = 1'b0;
      @(negedge clk);
      chk_eq("idle_we", {31'd0, rf_we}, 32'd0);

      // Load extension, rdata = 0x80FF7F01 (bytes 01,7F,FF,80)
      load_ext_vec("lb_a3", 3'd0, 2'd3, 32'hFFFFFF80);
      load_ext_vec("lbu_a1", 3'd4, 2'd1, 32'h0000007F);
      load_ext_vec("lbu_a2", 3'd4, 2'd2, 32'h000000FF);
      load_ext_vec("lb_a0", 3'd0, 2'd0, 32'h00000001);
      load_ext_vec("lh_a2", 3'd1, 2'd2, 32'hFFFF80FF);
      load_ext_vec("lhu_a0", 3'd5, 2'd0, 32'h00007F01);
      load_ext_vec("lhu_a3", 3'd5, 2'd3, 32'h000080FF);
      load_ext_vec("lw", 3'd2, 2'd0, 32'h80FF7F01);
      load_ext_vec("f3_7", 3'd7, 2'd1, 32'h80FF7F01);
      load_ext_vec("f3_3", 3'd3, 2'd3, 32'h80FF7F01);
      chk_eq("ld_rd", {27'd0, rf_rd}, 32'd7);

      // Priority and back-pressure: ALU busy every cycle while returns arrive
      alu_valid = 1'b1; alu_rd = 5'd1; alu_result = 32'h00000011;
      for (int i = 0; i < 4; i++) begin
         lsu_drive(5'(10 + i), 3'd2, 2'd0, 32'hA0000000 + 32'(i));
         @(negedge clk);
         chk_eq("bp_count", {29'd0, lq_count}, 32'(i + 1));
      end
      chk_eq("bp_alu_rd", {27'd0, rf_rd}, 32'd1);
      chk_eq("bp_ready_low", {31'd0, lsu_ready}, 32'd0);
      lsu_drive(5'd14, 3'd2, 2'd0, 32'hA0000004);
      @(negedge clk);
      chk_eq("bp_full_count", {29'd0, lq_count}, 32'd4);
      chk_eq("bp_full_ready", {31'd0, lsu_ready}, 32'd0);
      alu_valid = 1'b0; lsu_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk_eq("bp_pop_we", {31'd0, rf_we}, 32'd1);
         chk_eq("bp_pop_rd", {27'd0, rf_rd}, 32'(10 + i));
         chk_eq("bp_pop_data", rf_wdata, 32'hA0000000 + 32'(i));
      end
      chk_eq("bp_drain_ready", {31'd0, lsu_ready}, 32'd1);
      chk_eq("bp_drain_count", {29'd0, lq_count}, 32'd0);
      @(negedge clk);
      chk_eq("bp_after_we", {31'd0, rf_we}, 32'd0);

      // Scoreboard
      ld_issue = 1'b1; ld_issue_rd = 5'd9;
      @(negedge clk);
      ld_issue = 1'b0;
      chk_eq("sb_set", busy_mask, 32'h00000200);
      lsu_drive(5'd9, 3'd2, 2'd0, 32'h00000099);
      @(negedge clk);
      lsu_valid = 1'b0;
      chk_eq("sb_queued", busy_mask, 32'h00000200);
      @(negedge clk);
      chk_eq("sb_pop_we", {31'd0, rf_we}, 32'd1);
      chk_eq("sb_pop_rd", {27'd0, rf_rd}, 32'd9);
      chk_eq("sb_clear", busy_mask, 32'd0);
      ld_issue = 1'b1; ld_issue_rd = 5'd9;
      @(negedge clk);
      ld_issue = 1'b0;
      lsu_drive(5'd9, 3'd2, 2'd0, 32'h00000098);
      @(negedge clk);
      lsu_valid = 1'b0;
      ld_issue = 1'b1; ld_issue_rd = 5'd9;
      @(negedge clk);
      ld_issue = 1'b0;
      chk_eq("sb_same_we", {31'd0, rf_we}, 32'd1);
      chk_eq("sb_set_wins", busy_mask, 32'h00000200);
      lsu_drive(5'd9, 3'd2, 2'd0, 32'h00000097);
      @(negedge clk);
      lsu_valid = 1'b0;
      @(negedge clk);
      chk_eq("sb_clear2", busy_mask, 32'd0);
      ld_issue = 1'b1; ld_issue_rd = 5'd0;
      @(negedge clk);
      ld_issue = 1'b0;
      chk_eq("sb_x0", busy_mask, 32'd0);
      lsu_drive(5'd0, 3'd2, 2'd0, 32'h55555555);
      @(negedge clk);
      lsu_valid = 1'b0;
      @(negedge clk);
      chk_eq("ld_x0_we", {31'd0, rf_we}, 32'd0);
      chk_eq("ld_x0_count", {29'd0, lq_count}, 32'd0);
      chk_eq("ld_x0_data_hold", rf_wdata, 32'h00000097);

      // Wrap-around streaming: push and pop every cycle
      for (int k = 0; k <= 12; k++) begin
         if (k < 12) begin
            lsu_drive(5'(1 + k), 3'd2, 2'd0, 32'h01010101 * 32'(k));
         end else begin
            lsu_valid = 1'b0;
         end
         @(negedge clk);
         chk_eq("wrap_count", {29'd0, lq_count}, (k < 12) ? 32'd1 : 32'd0);
         if (k >= 1) begin
            chk_eq("wrap_we", {31'd0, rf_we}, 32'd1);
            chk_eq("wrap_rd", {27'd0, rf_rd}, 32'(k));
            chk_eq("wrap_data", rf_wdata, 32'h01010101 * 32'(k - 1));
         end
      end

      // Reset mid-operation with three queued returns
      alu_valid = 1'b1; alu_rd = 5'd3; alu_result = 32'h33333333;
      ld_issue = 1'b1; ld_issue_rd = 5'd9;
      lsu_drive(5'd20, 3'd2, 2'd0, 32'hC0000000);
      @(negedge clk);
      ld_issue_rd = 5'd10;
      lsu_drive(5'd21, 3'd2, 2'd0, 32'hC0000001);
      @(negedge clk);
      ld_issue = 1'b0;
      lsu_drive(5'd22, 3'd2, 2'd0, 32'hC0000002);
      @(negedge clk);
      alu_valid = 1'b0; lsu_valid = 1'b0;
      chk_eq("pre_rst_count", {29'd0, lq_count}, 32'd3);
      chk_eq("pre_rst_busy", busy_mask, 32'h00000600);
      chk_eq("pre_rst_we", {31'd0, rf_we}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_eq("mid_rst_we", {31'd0, rf_we}, 32'd0);
      chk_eq("mid_rst_busy", busy_mask, 32'd0);
      chk_eq("mid_rst_count", {29'd0, lq_count}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_eq("post_rst_we", {31'd0, rf_we}, 32'd0);
         chk_eq("post_rst_count", {29'd0, lq_count}, 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
